// File: rtl/spi_reg_burst_master.sv
// spi_reg_burst_master: SPI master for sensor register access with programmable SCLK divider
// and auto-incrementing multi-word burst reads/writes behind a start/busy/done handshake.
module spi_reg_burst_master #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1,
    parameter int BURST_W = 2
) (
    input  logic               FSM_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               rw,
    input  logic [ADDR_W-1:0]  reg_addr,
    input  logic [BURST_W-1:0] burst_len_m1,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_req,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               done,
    output logic               SPI_CLK,
    output logic               SPI_IN,
    input  logic               SPI_OUT,
    output logic               SPI_EN,
    output logic [2:0]         state
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'(CLK_DIV > 1 ? CLK_DIV - 2 : 0);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE = 3'd0, CMD, ADDR, WDATA, RDATA, FINISH} state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic               r_phase;
    logic [CNT_W-1:0]   r_cnt;
    logic [BURST_W-1:0] r_words;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-2:0]  r_rdsh;

    logic              w_half_end, w_rise, w_bit_end, w_pre_last, w_word_end, w_wr_next;
    logic [DATA_W-1:0] w_rd_word;

    assign state      = r_state;
    assign w_half_end = r_div == DIV_LAST;
    assign w_rise     = w_half_end && !r_phase;
    assign w_bit_end  = w_half_end && r_phase;
    // true one cycle before the last high-phase cycle of the current bit
    assign w_pre_last = (CLK_DIV == 1) ? w_rise : (r_phase && r_div == DIV_PRE);
    assign w_word_end = r_cnt == DATA_LAST;
    assign w_wr_next  = (r_state == ADDR && r_cnt == ADDR_LAST && r_rw) ||
                        (r_state == WDATA && w_word_end && r_words != '0);
    assign w_rd_word  = {r_rdsh, SPI_OUT};

    always_ff @(posedge FSM_clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
            r_words  <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdsh   <= '0;
            wr_req   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            SPI_CLK  <= 1'b0;
            SPI_IN   <= 1'b0;
            SPI_EN   <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            wr_req   <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= CMD;
                    r_rw    <= rw;
                    r_addr  <= reg_addr;
                    r_words <= burst_len_m1;
                    r_div   <= '0;
                    r_phase <= 1'b0;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    SPI_EN  <= 1'b1;
                    SPI_CLK <= 1'b0;
                    SPI_IN  <= rw;
                end
                CMD, ADDR, WDATA, RDATA: begin
                    wr_req <= w_pre_last && w_wr_next;
                    r_div  <= w_half_end ? '0 : r_div + 1'b1;
                    if (w_rise) begin
                        r_phase <= 1'b1;
                        SPI_CLK <= 1'b1;
                        if (r_state == RDATA) begin
                            r_rdsh <= w_rd_word[DATA_W-2:0];
                            if (w_word_end) begin
                                rd_data  <= w_rd_word;
                                rd_valid <= 1'b1;
                            end
                        end
                    end else if (w_bit_end) begin
                        r_phase <= 1'b0;
                        SPI_CLK <= 1'b0;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_state == CMD) begin
                            r_state <= ADDR;
                            r_cnt   <= '0;
                            SPI_IN  <= r_addr[ADDR_W-1];
                            r_addr  <= r_addr << 1;
                        end else if (r_state == ADDR) begin
                            if (r_cnt == ADDR_LAST) begin
                                r_state <= r_rw ? WDATA : RDATA;
                                r_cnt   <= '0;
                                SPI_IN  <= r_rw & wr_data[DATA_W-1];
                                r_wdata <= wr_data << 1;
                            end else begin
                                SPI_IN <= r_addr[ADDR_W-1];
                                r_addr <= r_addr << 1;
                            end
                        end else if (w_word_end) begin
                            r_cnt <= '0;
                            if (r_words == '0) begin
                                r_state <= FINISH;
                                SPI_IN  <= 1'b0;
                            end else begin
                                r_words <= r_words - 1'b1;
                                SPI_IN  <= (r_state == WDATA) & wr_data[DATA_W-1];
                                r_wdata <= wr_data << 1;
                            end
                        end else begin
                            SPI_IN  <= (r_state == WDATA) & r_wdata[DATA_W-1];
                            r_wdata <= r_wdata << 1;
                        end
                    end
                end
                FINISH: begin
                    r_div <= r_div + 1'b1;
                    if (w_half_end) begin
                        r_state <= IDLE;
                        SPI_EN  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_burst_master.sv
// tb_spi_reg_burst_master: directed bench for the default build and a CLK_DIV=3 build,
// with a MISO model that only presents valid data while SCLK is low.
module tb_spi_reg_burst_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, rw, start1, rw1;
    logic [6:0] reg_addr, addr1;
    logic [1:0] blen, blen1;
    logic [7:0] wr_data0, wr_data1, rd_data0, rd_data1;
    logic       wr_req0, rd_valid0, busy0, done0, SPI_CLK0, SPI_IN0, SPI_OUT0, SPI_EN0;
    logic       wr_req1, rd_valid1, busy1, done1, SPI_CLK1, SPI_IN1, SPI_OUT1, SPI_EN1;
    logic [2:0] state0, state1;

    spi_reg_burst_master u0 (
        .FSM_clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .reg_addr(reg_addr),
        .burst_len_m1(blen), .wr_data(wr_data0), .wr_req(wr_req0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .busy(busy0), .done(done0), .SPI_CLK(SPI_CLK0),
        .SPI_IN(SPI_IN0), .SPI_OUT(SPI_OUT0), .SPI_EN(SPI_EN0), .state(state0)
    );

    spi_reg_burst_master #(.CLK_DIV(3)) u1 (
        .FSM_clk(clk), .rst_n(rst_n), .start(start1), .rw(rw1), .reg_addr(addr1),
        .burst_len_m1(blen1), .wr_data(wr_data1), .wr_req(wr_req1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .busy(busy1), .done(done1), .SPI_CLK(SPI_CLK1),
        .SPI_IN(SPI_IN1), .SPI_OUT(SPI_OUT1), .SPI_EN(SPI_EN1), .state(state1)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int rise0 = 0, en0 = 0, enr0 = 0, wr0 = 0, rv0 = 0, dn0 = 0, done_cyc0 = 0, fall_cyc0 = 0, rv_cyc0 = 0;
    int rise1 = 0, en1 = 0, hi1 = 0, lo1 = 0, dn1 = 0, done_cyc1 = 0, fall_cyc1 = 0;
    int wr_cyc0 [64];
    logic mosi0 [1024];
    logic mosi1 [1024];
    logic pclk0 = 1'b0, pen0 = 1'b0, pclk1 = 1'b0, pen1 = 1'b0;
    int wp0 = 0, wbase = 0, rbase0 = 0, rbase1 = 0, idx0, idx1;
    logic [7:0] wwords [4];
    logic [7:0] miso0, miso1;
    int s0, s1, b_rise, b_en, b_enr, b_wr, b_dn, b_rv, b1_rise, b1_en, b1_hi, b1_lo, b1_dn;

    always @(negedge clk) begin
        cyc++;
        if (SPI_CLK0 && !pclk0) begin mosi0[rise0 & 1023] = SPI_IN0; rise0++; end
        if (SPI_EN0) en0++;
        if (SPI_EN0 && !pen0) enr0++;
        if (!SPI_EN0 && pen0) fall_cyc0 = cyc;
        if (wr_req0) begin wr_cyc0[wr0 & 63] = cyc; wr0++; end
        if (rd_valid0) begin rv0++; rv_cyc0 = cyc; end
        if (done0) begin dn0++; done_cyc0 = cyc; end
        pclk0 = SPI_CLK0;
        pen0 = SPI_EN0;
        if (SPI_CLK1 && !pclk1) begin mosi1[rise1 & 1023] = SPI_IN1; rise1++; end
        if (SPI_EN1) en1++;
        if (SPI_EN1 && SPI_CLK1) hi1++;
        if (SPI_EN1 && !SPI_CLK1) lo1++;
        if (!SPI_EN1 && pen1) fall_cyc1 = cyc;
        if (done1) begin dn1++; done_cyc1 = cyc; end
        pclk1 = SPI_CLK1;
        pen1 = SPI_EN1;
    end

    always @(posedge clk) if (wr_req0) wp0 <= wp0 + 1;

    always_comb begin
        wr_data0 = wwords[(wp0 - wbase) & 3];
        idx0 = rise0 - rbase0 - 8;
        idx1 = rise1 - rbase1 - 8;
        SPI_OUT0 = ((idx0 >= 0 && idx0 < 8) ? miso0[7 - idx0] : 1'b0) ^ SPI_CLK0;
        SPI_OUT1 = ((idx1 >= 0 && idx1 < 8) ? miso1[7 - idx1] : 1'b0) ^ SPI_CLK1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] stream0(input int b, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], mosi0[(b + i) & 1023]};
        return v;
    endfunction

    function automatic logic [63:0] stream1(input int b, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], mosi1[(b + i) & 1023]};
        return v;
    endfunction

    task automatic go0(input logic w, input logic [6:0] a, input logic [1:0] n);
        b_rise = rise0; b_en = en0; b_enr = enr0; b_wr = wr0; b_dn = dn0; b_rv = rv0;
        rbase0 = rise0;
        wbase = wp0;
        s0 = cyc + 1;
        start = 1'b1; rw = w; reg_addr = a; blen = n;
        tick();
        start = 1'b0; rw = ~w; reg_addr = ~a; blen = ~n;
        chk("accept_state", 64'(state0), 64'd1);
        chk("accept_busy", 64'(busy0), 64'd1);
        chk("accept_en", 64'(SPI_EN0), 64'd1);
    endtask

    task automatic wait_done0(input int base, input int lim);
        int n = 0;
        while (dn0 == base && n < lim) begin tick(); n++; end
        chk("done0_seen", 64'(dn0 != base), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; reg_addr = '0; blen = '0;
        start1 = 1'b0; rw1 = 1'b0; addr1 = '0; blen1 = '0; wr_data1 = '0;
        miso0 = '0; miso1 = '0;
        for (int i = 0; i < 4; i++) wwords[i] = '0;
        repeat (3) tick();
        chk("rst_en", 64'(SPI_EN0), 64'd0);
        chk("rst_clk", 64'(SPI_CLK0), 64'd0);
        chk("rst_in", 64'(SPI_IN0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_wrreq", 64'(wr_req0), 64'd0);
        chk("rst_rvalid", 64'(rd_valid0), 64'd0);
        chk("rst_rdata", 64'(rd_data0), 64'd0);
        chk("rst_state", 64'(state0), 64'd0);
        chk("rst_en1", 64'(SPI_EN1), 64'd0);
        rst_n = 1'b1;
        tick();

        // single write 0x2A <- 0x5C
        wwords[0] = 8'h5C;
        go0(1'b1, 7'h2A, 2'd0);
        wait_done0(b_dn, 200);
        chk("wr_rises", 64'(rise0 - b_rise), 64'd16);
        chk("wr_mosi", stream0(b_rise, 16), 64'hAA5C);
        chk("wr_en_time", 64'(en0 - b_en), 64'd33);
        chk("wr_reqs", 64'(wr0 - b_wr), 64'd1);
        chk("wr_req_cyc", 64'(wr_cyc0[b_wr & 63] - s0), 64'd16);
        chk("wr_dones", 64'(dn0 - b_dn), 64'd1);
        chk("wr_done_lat", 64'(done_cyc0 - s0), 64'd34);
        chk("wr_done_fall", 64'(done_cyc0 - fall_cyc0), 64'd0);
        chk("wr_idle_busy", 64'(busy0), 64'd0);

        // single read 0x11, sensor returns 0xA5
        miso0 = 8'hA5;
        go0(1'b0, 7'h11, 2'd0);
        wait_done0(b_dn, 200);
        chk("rd_rises", 64'(rise0 - b_rise), 64'd16);
        chk("rd_mosi", stream0(b_rise, 16), 64'h1100);
        chk("rd_data", 64'(rd_data0), 64'hA5);
        chk("rd_valids", 64'(rv0 - b_rv), 64'd1);
        chk("rd_valid_cyc", 64'(rv_cyc0 - s0), 64'd32);
        chk("rd_wrreqs", 64'(wr0 - b_wr), 64'd0);
        chk("rd_en_time", 64'(en0 - b_en), 64'd33);
        chk("rd_done_fall", 64'(done_cyc0 - fall_cyc0), 64'd0);

        // burst write N=3
        wwords[0] = 8'h01; wwords[1] = 8'h02; wwords[2] = 8'h03;
        go0(1'b1, 7'h05, 2'd2);
        wait_done0(b_dn, 300);
        chk("b3_rises", 64'(rise0 - b_rise), 64'd32);
        chk("b3_mosi", stream0(b_rise, 32), 64'h85010203);
        chk("b3_reqs", 64'(wr0 - b_wr), 64'd3);
        chk("b3_req0", 64'(wr_cyc0[b_wr & 63] - s0), 64'd16);
        chk("b3_req1", 64'(wr_cyc0[(b_wr + 1) & 63] - s0), 64'd32);
        chk("b3_req2", 64'(wr_cyc0[(b_wr + 2) & 63] - s0), 64'd48);
        chk("b3_en_time", 64'(en0 - b_en), 64'd65);

        // maximum burst: burst_len_m1=3 gives four words
        wwords[0] = 8'h11; wwords[1] = 8'h22; wwords[2] = 8'h33; wwords[3] = 8'h44;
        go0(1'b1, 7'h7F, 2'd3);
        wait_done0(b_dn, 300);
        chk("b4_rises", 64'(rise0 - b_rise), 64'd40);
        chk("b4_mosi", stream0(b_rise, 40), 64'hFF11223344);
        chk("b4_reqs", 64'(wr0 - b_wr), 64'd4);
        chk("b4_en_time", 64'(en0 - b_en), 64'd81);
        chk("b4_dones", 64'(dn0 - b_dn), 64'd1);

        // CLK_DIV=3 single read 0x33, sensor returns 0x3C
        b1_rise = rise1; b1_en = en1; b1_hi = hi1; b1_lo = lo1; b1_dn = dn1;
        rbase1 = rise1; miso1 = 8'h3C; s1 = cyc + 1;
        start1 = 1'b1; rw1 = 1'b0; addr1 = 7'h33;
        tick();
        start1 = 1'b0; rw1 = 1'b1; addr1 = 7'h00;
        for (int n = 0; n < 400 && dn1 == b1_dn; n++) tick();
        chk("d3_done_seen", 64'(dn1 - b1_dn), 64'd1);
        chk("d3_rises", 64'(rise1 - b1_rise), 64'd16);
        chk("d3_mosi", stream1(b1_rise, 16), 64'h3300);
        chk("d3_en_time", 64'(en1 - b1_en), 64'd99);
        chk("d3_high", 64'(hi1 - b1_hi), 64'd48);
        chk("d3_low", 64'(lo1 - b1_lo), 64'd51);
        chk("d3_rdata", 64'(rd_data1), 64'h3C);
        chk("d3_done_lat", 64'(done_cyc1 - s1), 64'd100);
        chk("d3_done_fall", 64'(done_cyc1 - fall_cyc1), 64'd0);

        // reset in the middle of the address phase
        wwords[0] = 8'h5C;
        go0(1'b1, 7'h2A, 2'd0);
        repeat (11) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_en", 64'(SPI_EN0), 64'd0);
        chk("abort_clk", 64'(SPI_CLK0), 64'd0);
        chk("abort_in", 64'(SPI_IN0), 64'd0);
        chk("abort_state", 64'(state0), 64'd0);
        chk("abort_busy", 64'(busy0), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("abort_no_done", 64'(dn0 - b_dn), 64'd0);
        go0(1'b1, 7'h2A, 2'd0);
        wait_done0(b_dn, 200);
        chk("post_abort_mosi", stream0(b_rise, 16), 64'hAA5C);
        chk("post_abort_dones", 64'(dn0 - b_dn), 64'd1);

        // start mid-frame is dropped; start in the done cycle is accepted
        wwords[0] = 8'h5C; wwords[1] = 8'h5C;
        go0(1'b1, 7'h2A, 2'd0);
        repeat (9) tick();
        start = 1'b1; rw = 1'b0; reg_addr = 7'h11;
        tick();
        start = 1'b0;
        repeat (23) tick();
        chk("dc_done_now", 64'(done0), 64'd1);
        start = 1'b1; rw = 1'b1; reg_addr = 7'h2A; blen = 2'd0;
        tick();
        start = 1'b0;
        chk("dc_restart_state", 64'(state0), 64'd1);
        chk("dc_restart_en", 64'(SPI_EN0), 64'd1);
        wait_done0(b_dn + 1, 200);
        repeat (40) tick();
        chk("dc_dones", 64'(dn0 - b_dn), 64'd2);
        chk("dc_frames", 64'(enr0 - b_enr), 64'd2);
        chk("dc_second_done", 64'(done_cyc0 - s0), 64'd68);
        chk("dc_mosi2", stream0(b_rise + 16, 16), 64'hAA5C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
